// File: rtl/univ_shift_reg_if.sv
// Control/status bundle for the universal shift register; the data bus
// stays a plain inout on the block so the tristate resolves in one place.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
);
  logic [2:0]     mode;
  logic           start;
  logic [SHW-1:0] shamt;
  logic           sin_r;
  logic           sin_l;
  logic           oe;
  logic           q_lsb;
  logic           q_msb;
  logic           busy;
  logic           done;

  modport master (
    output mode, start, shamt, sin_r, sin_l, oe,
    input  q_lsb, q_msb, busy, done
  );

  modport slave (
    input  mode, start, shamt, sin_r, sin_l, oe,
    output q_lsb, q_msb, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: single-cycle load/clear/hold, and multi-cycle
// shift/rotate that takes one single-bit step per clock for shamt clocks.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  univ_shift_reg_if.slave  bus,
  inout  wire  [WIDTH-1:0] data
);
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LSR  = 3'b001;
  localparam logic [2:0] M_SL   = 3'b010;
  localparam logic [2:0] M_ASR  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_LOAD = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_step;
  logic [2:0]       r_mode;
  logic [SHW-1:0]   r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             w_drive;

  // Serial inputs are taken live at each step edge, not latched at start.
  always_comb begin
    w_step = r_q;
    case (r_mode)
      M_LSR:   w_step = {bus.sin_r, r_q[WIDTH-1:1]};
      M_SL:    w_step = {r_q[WIDTH-2:0], bus.sin_l};
      M_ASR:   w_step = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      M_ROR:   w_step = {r_q[0], r_q[WIDTH-1:1]};
      M_ROL:   w_step = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      default: w_step = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_mode <= M_HOLD;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_q   <= w_step;
        r_cnt <= r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (bus.start) begin
        case (bus.mode)
          M_LOAD: begin
            r_q    <= data;
            r_done <= 1'b1;
          end
          M_CLR: begin
            r_q    <= '0;
            r_done <= 1'b1;
          end
          M_HOLD: r_done <= 1'b1;
          default: begin
            if (bus.shamt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_mode <= bus.mode;
              r_cnt  <= bus.shamt;
              r_busy <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Live mode gates the driver so a pending load never fights the source.
  assign w_drive   = rst_n & bus.oe & (bus.mode != M_LOAD);
  assign data      = w_drive ? r_q : {WIDTH{1'bz}};

  assign bus.q_lsb = r_q[0];
  assign bus.q_msb = r_q[WIDTH-1];
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: an arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed register values.
module tb_univ_shift_reg;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       tb_en  = 1'b0;
  logic [7:0] tb_val = 8'h00;
  wire  [7:0] data;

  int n_chk  = 0;
  int n_pass = 0;

  univ_shift_reg_if #(.WIDTH(W), .SHW(4)) bus ();

  univ_shift_reg #(.WIDTH(W), .SHW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .data  (data)
  );

  assign data = tb_en ? tb_val : 8'bz;

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       m_q    = 0;
  bit       m_busy = 0;
  bit       m_done = 0;
  int       m_left = 0;
  int       m_mode = 0;

  function automatic int m_step(input int q, input int md, input bit sr, input bit sl);
    case (md)
      1: return q / 2 + (sr ? 128 : 0);
      2: return (q * 2) % 256 + (sl ? 1 : 0);
      3: return q / 2 + (q >= 128 ? 128 : 0);
      4: return q / 2 + (q % 2) * 128;
      5: return (q * 2) % 256 + q / 128;
      default: return q;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = 0; m_busy = 0; m_done = 0; m_left = 0; m_mode = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_q = m_step(m_q, m_mode, bus.sin_r, bus.sin_l);
        m_left = m_left - 1;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end else if (bus.start) begin
        case (int'(bus.mode))
          6: begin m_q = int'(data); m_done = 1; end
          7: begin m_q = 0; m_done = 1; end
          0: m_done = 1;
          default: begin
            if (bus.shamt == 0) m_done = 1;
            else begin m_busy = 1; m_left = int'(bus.shamt); m_mode = int'(bus.mode); end
          end
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    chk("busy",  int'(bus.busy),  int'(m_busy));
    chk("done",  int'(bus.done),  int'(m_done));
    chk("q_lsb", int'(bus.q_lsb), m_q % 2);
    chk("q_msb", int'(bus.q_msb), m_q / 128);
    chk("busy_done_excl", int'(bus.busy & bus.done), 0);
    if (tb_en)
      chk("data_z", int'(data), int'(tb_val));
    else if (rst_n && bus.oe && bus.mode != 3'b110)
      chk("data_q", int'(data), m_q);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    bus.mode = 3'b110; tb_en = 1'b1; tb_val = v; bus.start = 1'b1;
    tick;
    bus.start = 1'b0; tb_en = 1'b0; bus.mode = 3'b000; bus.oe = 1'b1;
  endtask

  task automatic go(input logic [2:0] md, input logic [3:0] n);
    bus.mode = md; bus.shamt = n; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] rol_exp [4];
    rol_exp[0] = 8'h4B; rol_exp[1] = 8'h96; rol_exp[2] = 8'h2D; rol_exp[3] = 8'h5A;
    bus.mode = 3'b000; bus.start = 1'b0; bus.shamt = 4'd0;
    bus.sin_r = 1'b0; bus.sin_l = 1'b0; bus.oe = 1'b0;

    // Reset state, with the bench driving the bus to expose any contention.
    tb_en = 1'b1; tb_val = 8'h3C; bus.oe = 1'b1;
    repeat (2) tick;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_q",    int'({bus.q_msb, bus.q_lsb}), 0);
    chk("rst_data_z", int'(data), 8'h3C);
    tb_en = 1'b0; bus.oe = 1'b0;
    rst_n = 1'b1;

    // Load A5 on the first edge after release.
    load(8'hA5);
    chk("load_done", int'(bus.done), 1);
    chk("load_busy", int'(bus.busy), 0);
    chk("load_lsb",  int'(bus.q_lsb), 1);
    chk("load_msb",  int'(bus.q_msb), 1);
    chk("load_data", int'(data), 8'hA5);
    tick;
    chk("load_done_1cyc", int'(bus.done), 0);

    // Rotate left by 4 with intermediates.
    go(3'b101, 4'd4);
    chk("rol_busy0", int'(bus.busy), 1);
    chk("rol_nostep", int'(data), 8'hA5);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rol_step", int'(data), int'(rol_exp[i]));
    end
    chk("rol_done", int'(bus.done), 1);
    tick;

    // Arithmetic right by 3 from 96.
    load(8'h96);
    go(3'b011, 4'd3);
    tick; tick;
    chk("asr_busy", int'(bus.busy), 1);
    tick;
    chk("asr_busy_clr", int'(bus.busy), 0);
    chk("asr_done", int'(bus.done), 1);
    chk("asr_q", int'(data), 8'hF2);
    tick;

    // Over-width left shift of zero with sin_l=1.
    bus.mode = 3'b111; bus.start = 1'b1; tick; bus.start = 1'b0;
    chk("clr_q", int'(data), 0);
    bus.sin_l = 1'b1;
    go(3'b010, 4'd9);
    n = 0;
    while (bus.busy && n < 20) begin tick; n++; end
    chk("sl9_cycles", n, 9);
    chk("sl9_q", int'(data), 8'hFF);
    bus.sin_l = 1'b0;
    tick;

    // Start with clear while busy is ignored.
    load(8'h81);
    go(3'b001, 4'd3);
    bus.mode = 3'b111; bus.shamt = 4'd1; bus.start = 1'b1;
    tick;
    bus.start = 1'b0; bus.mode = 3'b000;
    tick; tick;
    chk("ign_done", int'(bus.done), 1);
    chk("ign_q", int'(data), 8'h10);
    tick;

    // Null start: shamt 0 in logical right.
    go(3'b001, 4'd0);
    chk("null_busy", int'(bus.busy), 0);
    chk("null_done", int'(bus.done), 1);
    chk("null_q", int'(data), 8'h10);
    tick;

    // Reset mid-operation after 2 steps.
    load(8'hFF);
    go(3'b001, 4'd5);
    tick; tick;
    chk("mid_q", int'(data), 8'h3F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_q", int'({bus.q_msb, bus.q_lsb}), 0);
    tb_en = 1'b1; tb_val = 8'h5A;
    #1;
    chk("mid_rst_z", int'(data), 8'h5A);
    tick;
    tb_en = 1'b0;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.done) n++;
    end
    chk("mid_no_done", n, 0);
    chk("mid_q_after", int'(data), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register and data-bus width, minimum 2.
REQ-002 SHALL have parameter SHW, default 4: width of the shift-amount input.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are listed first, below.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 mode  in  3  operation select; sampled only on an accepted start.
REQ-007 start  in  1  request to begin the operation given by mode.
REQ-008 shamt  in  SHW  number of single-bit steps for shift/rotate modes.
REQ-009 sin_r  in  1  serial input entering the MSB on logical right shift.
REQ-010 sin_l  in  1  serial input entering the LSB on left shift.
REQ-011 oe  in  1  bus output enable.
REQ-012 data  inout  WIDTH  bidirectional parallel bus.
REQ-013 q_lsb  out  1  register bit 0.
REQ-014 q_msb  out  1  register bit WIDTH-1.
REQ-015 busy  out  1  multi-cycle operation in progress.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 mode encoding SHALL be:
- 000 hold
- 001 logical right (sin_r into MSB)
- 010 left (sin_l into LSB)
- 011 arithmetic right (MSB replicated)
- 100 rotate right
- 101 rotate left
- 110 parallel load from data
- 111 clear to 0
REQ-018 start SHALL be accepted only on a rising edge where busy=0; start while busy=1 SHALL be ignored with no effect on mode, count or register.
REQ-019 Accepted start with mode 110 or 111 SHALL update the register at that edge, keep busy=0 and assert done for the following cycle.
REQ-020 Accepted start with mode 000, or with a shift/rotate mode and shamt=0, SHALL leave the register unchanged, keep busy=0 and assert done for the following cycle.
REQ-021 Accepted start with a shift/rotate mode and shamt=N>0 at edge k SHALL latch mode and N, set busy=1 and perform no step at edge k.
REQ-022 Such an operation SHALL perform one single-bit step at each of edges k+1..k+N.
REQ-023 At edge k+N busy SHALL clear and done SHALL assert for exactly one cycle.
REQ-024 sin_r and sin_l SHALL be sampled at each step edge, not at start.
REQ-025 N greater than or equal to WIDTH SHALL be legal and SHALL execute exactly N steps; for example, a logical shift then fully refills from the serial input.
REQ-026 During busy, changes on mode and shamt SHALL NOT affect the operation in progress.
REQ-027 data SHALL be driven with the register value when rst_n=1, oe=1 and the live mode input is not 110; otherwise data SHALL be high-impedance.
REQ-028 q_lsb and q_msb SHALL be combinational from the register and valid in every cycle, including during busy.
REQ-029 done SHALL never be high in the same cycle as busy.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force register=0, internal count=0, busy=0, done=0 and data high-impedance, independent of clk.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-032 After reset release, the first rising edge SHALL accept a start.

Verification
REQ-033 Load (WIDTH=8):
- stimulus: oe=0, data=A5h, mode=110, start for 1 cycle
- response: register=A5h, q_lsb=1, q_msb=1, busy stays 0, done=1 for 1 cycle; with oe=1 and mode=000, data reads A5h.
REQ-034 Arithmetic right:
- stimulus: register=96h, mode=011, shamt=3, start
- response: busy=1 for 3 cycles, then register=F2h and done=1 for 1 cycle.
REQ-035 Rotate left:
- stimulus: register=A5h, mode=101, shamt=4
- response: register=5Ah after 4 steps; intermediates 4Bh, 96h, 2Dh, 5Ah.
REQ-036 Over-width left shift:
- stimulus: register=00h, mode=010, sin_l=1, shamt=9
- response: register=FFh, busy high for 9 cycles.
REQ-037 Reset mid-operation:
- stimulus: register=FFh, mode=001, shamt=5, start; rst_n low after 2 steps
- response: register=00h, busy=0 and data=Z immediately, no done pulse.
REQ-038 Ignored and null starts:
- stimulus 1: start with mode=111 while busy
- response 1: ignored; the result equals that of an uninterrupted shift.
- stimulus 2: start with shamt=0, mode=001
- response 2: register unchanged, done=1 next cycle, busy never high.
